id_ex_decode_stage: RTL
=======================

// Module: id_ex_decode_stage
// PURPOSE
// - Decode stage plus ID/EX pipeline register of the 5-stage pipeline; producer of the ALU op1/op2/aluop interface.
// - Decodes one RV32I instruction per cycle, selects operands (register, immediate, PC, constant) and encodes the 6-bit ALU opcode.
// - Registers the result with valid/stall/flush control so EX sees stable, aligned inputs.
// PARAMETERS
// - XLEN        32  datapath width; only 32 is supported.
// - ALUOP_W     6   ALU opcode width; must match the ALU.
// - REG_ADDR_W  5   register-file address width.
// PORTS
// - clk_i         in   1     clock; all state updates on rising edge
// - rst_i         in   1     synchronous, active-high reset
// - valid_i       in   1     instr_i/pc_i hold a real instruction from IF/ID
// - instr_i       in   32    instruction word
// - pc_i          in   32    PC of instr_i
// - rs1_data_i    in   32    regfile read data for rs1_addr_o (already forwarded)
// - rs2_data_i    in   32    regfile read data for rs2_addr_o (already forwarded)
// - stall_i       in   1     hazard unit: hold ID/EX contents
// - flush_i       in   1     branch/jump redirect: kill the instruction being captured
// - rs1_addr_o    out  5     combinational instr_i[19:15]
// - rs2_addr_o    out  5     combinational instr_i[24:20]
// - ready_o       out  1     combinational ~stall_i; IF/ID advances only when high
// - valid_o       out  1     ID/EX holds a live instruction
// - op1_o         out  32   ALU operand 1
// - op2_o         out  32   ALU operand 2
// - aluop_o       out  6     0 ADD,1 SLL,2 SLT,3 SLTU,4 XOR,5 SRL,6 OR,7 AND,8 SRA,9 SUB
// - store_data_o  out  32   rs2 value for stores
// - rd_addr_o     out  5     destination register
// - rd_we_o       out  1     writeback enable (forced 0 when rd=x0)
// - mem_rd_o      out  1     load
// - mem_wr_o      out  1     store
// - branch_o      out  1     conditional branch; funct3_o qualifies compare
// - funct3_o      out  3     instr funct3, passed through
// - illegal_o     out  1     unsupported/illegal encoding
// BEHAVIOUR
// - Reset (rst_i=1 at edge): every registered output 0 (aluop_o=ADD=0); reset wins over stall/flush.
// - Latency: 1 cycle; inputs at edge N appear on outputs after edge N.
// - Update priority per edge: rst_i > flush_i > stall_i > capture.
// - flush_i: valid_o<=0, rd_we_o/mem_rd_o/mem_wr_o/branch_o/illegal_o<=0; datapath outputs don't-care, driven 0.
// - stall_i (no flush): all outputs hold; flush+stall together -> bubble.
// - capture: valid_o<=valid_i; when valid_i=0 all control outputs <=0.
// - Operand selection:
//   - R-type: op1=rs1, op2=rs2; funct7[5] selects SUB/SRA.
//   - I-ALU: op1=rs1, op2=sext(imm12); SLTIU compares with sign-extended imm as unsigned.
//   - Shifts (reg and imm): op2 = {27'b0, shamt[4:0]}; rs2 bits [31:5] always masked (ALU shifts by full op2).
//   - SLLI/SRLI/SRAI with imm[11:5] not 0000000/0100000 -> illegal.
//   - LOAD/STORE: ADD rs1+sext(imm).
//   - LUI: op1=0, op2=imm<<12, ADD.  AUIPC: op1=pc, op2=imm<<12, ADD.
//   - JAL/JALR: op1=pc, op2=4, ADD (link value); rd_we per rd.
//   - BRANCH: op1=rs1, op2=rs2, SUB, branch_o=1, rd_we_o=0.
// - Illegal/unknown opcode, or funct3/funct7 not in RV32I: illegal_o=1, aluop_o=ADD, rd_we/mem_*/branch all 0, valid_o still 1.
// - FENCE/ECALL/EBREAK: legal no-ops (all write/memory enables 0).
// - rd=x0: rd_we_o=0 regardless of type.
// STRUCTURE
// - Package pipe_pkg: aluop constants (ALU_ADD..ALU_SUB), RV32I opcode constants, imm-type enum.
// - Sub-module imm_gen (combinational I/S/B/U/J immediate extraction); decode logic and ID/EX register in top.
// TESTING
// - ADD x3,x1,x2 (rs1=5,rs2=7) -> 1 cycle later op1=5,op2=7,aluop=0,rd=3,rd_we=1,valid=1.
// - SRA x4,x1,x2, rs2=0xFFFF_FFE3 -> op2=0x0000_0003, aluop=8; SRAI imm[11:5]=0x20 -> aluop=8; 0x10 -> illegal_o=1.
// - LUI x5,0xABCDE -> op1=0, op2=0xABCDE000, aluop=0; AUIPC at pc=0x100 -> op1=0x100.
// - stall_i=1 for 3 cycles with new instr_i -> outputs unchanged, ready_o=0; stall+flush same cycle -> valid_o=0.
// - ADDI x0,x0,1 -> rd_we_o=0; opcode 0x7F -> illegal_o=1, rd_we_o=0, aluop=0.
// - rst_i mid-stream with valid_i=1 -> next cycle all outputs 0; first instr after release captured normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline: ALU opcodes, RV32I major opcodes and
// the immediate-format selector used between decode and imm_gen.
package pipe_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SLL  = 6'd1;
  localparam logic [5:0] ALU_SLT  = 6'd2;
  localparam logic [5:0] ALU_SLTU = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_OR   = 6'd6;
  localparam logic [5:0] ALU_AND  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SUB  = 6'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; takes instr[31:7] since the
// opcode field never contributes immediate bits.
module imm_gen
  import pipe_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_type_e   i_type,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    unique case (i_type)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode with operand selection and ALU opcode encoding, followed by
// the ID/EX pipeline register (reset > flush > stall > capture).
module id_ex_decode_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALUOP_W    = 6,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [31:0]           instr_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_we_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic                  branch_o,
  output logic [2:0]            funct3_o,
  output logic                  illegal_o
);

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [ALUOP_W-1:0]    aluop;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  branch;
    logic [2:0]            funct3;
    logic                  illegal;
  } idex_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  imm_type_e   w_imm_type;
  logic [31:0] w_imm;
  idex_t       w_dec;
  logic        w_legal;
  logic        w_has_rd;
  idex_t       r_idex;

  assign w_opcode   = instr_i[6:0];
  assign w_funct3   = instr_i[14:12];
  assign w_funct7   = instr_i[31:25];
  assign w_rd       = instr_i[11:7];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign ready_o    = ~stall_i;

  always_comb begin
    w_imm_type = IMM_I;
    unique case (w_opcode)
      OPC_STORE:           w_imm_type = IMM_S;
      OPC_BRANCH:          w_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:  w_imm_type = IMM_U;
      OPC_JAL:             w_imm_type = IMM_J;
      default:             w_imm_type = IMM_I;
    endcase
  end

  imm_gen u_imm_gen (
    .i_instr (instr_i[31:7]),
    .i_type  (w_imm_type),
    .o_imm   (w_imm)
  );

  // funct3 maps 1:1 onto ALU_ADD..ALU_AND; only SUB and SRA need remapping.
  always_comb begin
    w_dec          = '0;
    w_legal        = 1'b1;
    w_has_rd       = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.rd_addr  = w_rd;
    w_dec.funct3   = w_funct3;
    w_dec.aluop    = ALU_ADD;
    unique case (w_opcode)
      OPC_OP: begin
        w_has_rd  = 1'b1;
        w_dec.op1 = rs1_data_i;
        w_dec.op2 = rs2_data_i;
        w_dec.aluop = {3'b000, w_funct3};
        if (w_funct3 == 3'd1 || w_funct3 == 3'd5)
          w_dec.op2 = {{(XLEN-5){1'b0}}, rs2_data_i[4:0]};
        if (w_funct7 == 7'h20) begin
          if (w_funct3 == 3'd0)      w_dec.aluop = ALU_SUB;
          else if (w_funct3 == 3'd5) w_dec.aluop = ALU_SRA;
          else                       w_legal = 1'b0;
        end else if (w_funct7 != 7'h00) begin
          w_legal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        w_has_rd    = 1'b1;
        w_dec.op1   = rs1_data_i;
        w_dec.op2   = w_imm;
        w_dec.aluop = {3'b000, w_funct3};
        if (w_funct3 == 3'd1 || w_funct3 == 3'd5) begin
          w_dec.op2 = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          if (w_funct3 == 3'd5 && w_funct7 == 7'h20) w_dec.aluop = ALU_SRA;
          else if (w_funct7 != 7'h00)                w_legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        w_has_rd     = 1'b1;
        w_dec.mem_rd = 1'b1;
        w_dec.op1    = rs1_data_i;
        w_dec.op2    = w_imm;
        if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7)
          w_legal = 1'b0;
      end
      OPC_STORE: begin
        w_dec.mem_wr     = 1'b1;
        w_dec.op1        = rs1_data_i;
        w_dec.op2        = w_imm;
        w_dec.store_data = rs2_data_i;
        if (w_funct3 > 3'd2) w_legal = 1'b0;
      end
      OPC_BRANCH: begin
        w_dec.branch = 1'b1;
        w_dec.op1    = rs1_data_i;
        w_dec.op2    = rs2_data_i;
        w_dec.aluop  = ALU_SUB;
        if (w_funct3 == 3'd2 || w_funct3 == 3'd3) w_legal = 1'b0;
      end
      OPC_LUI: begin
        w_has_rd  = 1'b1;
        w_dec.op2 = w_imm;
      end
      OPC_AUIPC: begin
        w_has_rd  = 1'b1;
        w_dec.op1 = pc_i;
        w_dec.op2 = w_imm;
      end
      OPC_JAL, OPC_JALR: begin
        w_has_rd  = 1'b1;
        w_dec.op1 = pc_i;
        w_dec.op2 = XLEN'(4);
        if (w_opcode == OPC_JALR && w_funct3 != 3'd0) w_legal = 1'b0;
      end
      OPC_MISC: begin
        if (w_funct3 != 3'd0) w_legal = 1'b0;
      end
      OPC_SYSTEM: begin
        if (!(instr_i[31:7] == 25'd0 ||
              (instr_i[31:20] == 12'h001 && instr_i[19:7] == 13'd0)))
          w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      w_dec            = '0;
      w_dec.valid      = 1'b1;
      w_dec.rd_addr    = w_rd;
      w_dec.funct3     = w_funct3;
      w_dec.illegal    = 1'b1;
      w_has_rd         = 1'b0;
    end
    w_dec.rd_we = w_has_rd && (w_rd != 5'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          r_idex <= '0;
    else if (flush_i)   r_idex <= '0;
    else if (!stall_i)  r_idex <= valid_i ? w_dec : '0;
  end

  assign valid_o      = r_idex.valid;
  assign op1_o        = r_idex.op1;
  assign op2_o        = r_idex.op2;
  assign aluop_o      = r_idex.aluop;
  assign store_data_o = r_idex.store_data;
  assign rd_addr_o    = r_idex.rd_addr;
  assign rd_we_o      = r_idex.rd_we;
  assign mem_rd_o     = r_idex.mem_rd;
  assign mem_wr_o     = r_idex.mem_wr;
  assign branch_o     = r_idex.branch;
  assign funct3_o     = r_idex.funct3;
  assign illegal_o    = r_idex.illegal;

endmodule
